// File: rtl/regfile_2w_sb_pkg.sv
// Shared defaults for the dual-write register file with its busy scoreboard.
package regfile_2w_sb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;
    localparam int NUM_RD     = 2;
endpackage

// File: rtl/regfile_2w_sb_if.sv
// Register-file bus: read ports, two write ports, issue marking and scoreboard status.
interface regfile_2w_sb_if
    import regfile_2w_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              rs_busy;
    logic              rt_busy;
    logic              equal;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output rs_addr, rt_addr, we0, wa0, wd0, we1, wa1, wd1, issue_valid, issue_addr,
        input  read_data_1, read_data_2, rs_busy, rt_busy, equal, busy_count
    );

    modport slave (
        input  rs_addr, rt_addr, we0, wa0, wd0, we1, wa1, wd1, issue_valid, issue_addr,
        output read_data_1, read_data_2, rs_busy, rt_busy, equal, busy_count
    );
endinterface

// File: rtl/regfile_2w_sb_bypass_mux.sv
// One read port: zero-register, write-port-1, write-port-0, then stored value.
module regfile_bypass_mux
    import regfile_2w_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              reg_busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    logic hit0, hit1, is_zero;

    assign hit0    = we0 && (wa0 == addr);
    assign hit1    = we1 && (wa1 == addr);
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));

    always_comb begin
        data = reg_data;
        if (is_zero)   data = '0;
        else if (hit1) data = wd1;
        else if (hit0) data = wd0;
    end

    // A retiring write seen on the bypass means the operand is already available.
    assign busy = reg_busy && !hit0 && !hit1 && !is_zero;
endmodule

// File: rtl/regfile_2w_sb.sv
// Two-read / two-write register file with write bypass, busy scoreboard and operand compare.
module regfile_2w_sb
    import regfile_2w_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           reset,
    regfile_2w_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [DEPTH-1:0]              busy, busy_nxt;
    logic [ADDR_W:0]               count, n_set, n_clr;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;

    assign rd_addr = {bus.rt_addr, bus.rs_addr};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_bypass_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_mux (
            .addr    (rd_addr[g]),
            .reg_data(regs[rd_addr[g]]),
            .reg_busy(busy[rd_addr[g]]),
            .we0     (bus.we0),
            .wa0     (bus.wa0),
            .wd0     (bus.wd0),
            .we1     (bus.we1),
            .wa1     (bus.wa1),
            .wd1     (bus.wd1),
            .data    (rd_data[g]),
            .busy    (rd_busy[g])
        );
    end

    assign bus.read_data_1 = rd_data[0];
    assign bus.read_data_2 = rd_data[1];
    assign bus.rs_busy     = rd_busy[0];
    assign bus.rt_busy     = rd_busy[1];
    assign bus.equal       = (rd_data[0] == rd_data[1]);
    assign bus.busy_count  = count;

    // Issue beats retire on the same register: the new producer owns it.
    always_comb begin
        busy_nxt = busy;
        n_set    = '0;
        n_clr    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((bus.we0 && bus.wa0 == ADDR_W'(i)) || (bus.we1 && bus.wa1 == ADDR_W'(i)))
                busy_nxt[i] = 1'b0;
            if (bus.issue_valid && bus.issue_addr == ADDR_W'(i))
                busy_nxt[i] = 1'b1;
            if (ZERO_REG != 0 && i == ZERO_ADDR)
                busy_nxt[i] = 1'b0;
            n_set = n_set + (ADDR_W+1)'(busy_nxt[i] & ~busy[i]);
            n_clr = n_clr + (ADDR_W+1)'(busy[i] & ~busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_nxt;
            count <= count + n_set - n_clr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == ZERO_ADDR)) begin
                    if (bus.we1 && bus.wa1 == ADDR_W'(i))      regs[i] <= bus.wd1;
                    else if (bus.we0 && bus.wa0 == ADDR_W'(i)) regs[i] <= bus.wd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_2w_sb.sv
// Directed vector bench for regfile_2w_sb: reset sweep, vector table, mid-run reset.
module tb_regfile_2w_sb;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_2w_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_2w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] e_rd1, e_rd2;
        logic        e_rsb, e_rtb, e_eq;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] rs, rt, input logic we0, input logic [4:0] wa0,
                       input logic [31:0] wd0, input logic we1, input logic [4:0] wa1,
                       input logic [31:0] wd1, input logic iv, input logic [4:0] ia,
                       input logic [31:0] e_rd1, e_rd2, input logic e_rsb, e_rtb, e_eq,
                       input logic [5:0] e_cnt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.iv = iv; v.ia = ia;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_rsb = e_rsb; v.e_rtb = e_rtb;
        v.e_eq = e_eq; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
        bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
        bus.issue_valid = 0; bus.issue_addr = 0;
    endtask

    task automatic check(input string name, input logic [31:0] rd1, rd2,
                         input logic rsb, rtb, eq, input logic [5:0] cnt);
        n_tests++;
        if (bus.read_data_1 !== rd1 || bus.read_data_2 !== rd2 || bus.rs_busy !== rsb ||
            bus.rt_busy !== rtb || bus.equal !== eq || bus.busy_count !== cnt) begin
            n_fail++;
            $display("FAIL %s: got rd1=%h rd2=%h rsb=%b rtb=%b eq=%b cnt=%0d, want rd1=%h rd2=%h rsb=%b rtb=%b eq=%b cnt=%0d",
                     name, bus.read_data_1, bus.read_data_2, bus.rs_busy, bus.rt_busy,
                     bus.equal, bus.busy_count, rd1, rd2, rsb, rtb, eq, cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        bus.rs_addr = 0; bus.rt_addr = 0;

        // Expected outputs are sampled before the edge that commits each vector.
        add(7, 7, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 32'h22, 32'h22, 0, 0, 1, 0);
        add(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22, 32'h0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22, 0, 0, 0, 0);
        add(5, 5, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0);
        add(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        add(5, 7, 0, 0, 0, 1, 5, 32'hABCD, 0, 0, 32'hABCD, 32'h22, 0, 0, 0, 1);
        add(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hABCD, 32'hABCD, 0, 0, 1, 0);
        add(9, 5, 1, 9, 32'h1, 0, 0, 0, 1, 9, 32'h1, 32'hABCD, 0, 0, 0, 0);
        add(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h1, 1, 1, 1, 1);
        add(10, 11, 1, 10, 32'h77, 1, 11, 32'h88, 0, 0, 32'h77, 32'h88, 0, 0, 0, 1);
        add(10, 11, 0, 0, 0, 0, 0, 0, 1, 12, 32'h77, 32'h88, 0, 0, 0, 1);
        add(12, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 1, 1, 0, 2);
        add(12, 9, 1, 12, 32'h3, 1, 9, 32'h3, 0, 0, 32'h3, 32'h3, 0, 0, 1, 2);
        add(12, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3, 32'h3, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            bus.rt_addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rd[%0d]", i), 0, 0, 0, 0, 1, 0);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            bus.rs_addr = vecs[k].rs;  bus.rt_addr = vecs[k].rt;
            bus.we0 = vecs[k].we0;     bus.wa0 = vecs[k].wa0; bus.wd0 = vecs[k].wd0;
            bus.we1 = vecs[k].we1;     bus.wa1 = vecs[k].wa1; bus.wd1 = vecs[k].wd1;
            bus.issue_valid = vecs[k].iv; bus.issue_addr = vecs[k].ia;
            #1;
            check($sformatf("vec[%0d]", k), vecs[k].e_rd1, vecs[k].e_rd2,
                  vecs[k].e_rsb, vecs[k].e_rtb, vecs[k].e_eq, vecs[k].e_cnt);
        end

        // Mid-run reset: build up busy state, then reset while a write is in flight.
        @(negedge clk);
        drive_idle();
        bus.issue_valid = 1; bus.issue_addr = 3;
        @(negedge clk);
        bus.issue_addr = 4;
        @(negedge clk);
        drive_idle();
        bus.rs_addr = 3; bus.rt_addr = 4;
        #1;
        check("busy_3_4", 0, 0, 1, 1, 1, 2);
        bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'h5;
        bus.rt_addr = 3;
        #1;
        check("bypass_3", 32'h5, 32'h5, 0, 0, 1, 2);
        reset = 1'b1;
        #1;
        check("rst_async_bypass", 32'h5, 32'h5, 0, 0, 1, 0);
        bus.we0 = 0;
        bus.rt_addr = 4;
        #1;
        check("rst_async_idle", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.rs_addr = 3; bus.rt_addr = 9;
        #1;
        check("after_rst_lost_write", 0, 0, 0, 0, 1, 0);
        bus.rs_addr = 12; bus.rt_addr = 7;
        #1;
        check("after_rst_regs_clear", 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, want finish before 50000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_2w_sb.md
Name: regfile_2w_sb

Overview:
- Parametrised successor to the single-write register file for the dual-writeback pipeline.
- Provides 2 asynchronous read ports, 2 synchronous write ports and write-to-read bypass.
- Tracks a per-register busy scoreboard, giving decode stall information.
- Keeps the combinational equality compare used for early branch resolution.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 hardwired to zero and never marked busy

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
rs_addr  in  ADDR_W  read port A address
rt_addr  in  ADDR_W  read port B address
read_data_1  out  DATA_W  port A data, bypassed
read_data_2  out  DATA_W  port B data, bypassed
rs_busy  out  1  port A register has a pending producer
rt_busy  out  1  port B register has a pending producer
equal  out  1  read_data_1 == read_data_2
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
issue_valid  in  1  instruction issued with a destination register
issue_addr  in  ADDR_W  destination register to mark busy
busy_count  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (async, active-high):
  - All registers clear to 0 and all busy bits clear.
  - Outputs follow combinationally: read_data_* = 0 (unless a write is bypassing), rs_busy = rt_busy = 0, busy_count = 0, equal = 1.
- Writes:
  - On the clk rising edge, weN=1 writes wdN to regs[waN].
  - Same address on both ports in one cycle: port 1 wins; port 0 is dropped.
  - ZERO_REG=1: writes to address 0 are ignored; regs[0] always reads 0.
- Reads: combinational, zero latency. Priority per read port:
  - addr==0 with ZERO_REG=1 -> 0;
  - else we1 && wa1==addr -> wd1;
  - else we0 && wa0==addr -> wd0;
  - else regs[addr].
- equal: compares the bypassed read_data_1 and read_data_2; combinational.
- Scoreboard, one busy bit per register, evaluated per edge:
  - Clear when any write port writes that address.
  - Set when issue_valid && issue_addr==that address.
  - Set takes priority over clear in the same cycle: a new producer supersedes the retiring one.
  - Issue to address 0 with ZERO_REG=1 is ignored.
- rs_busy / rt_busy:
  - Equal busy[addr], except forced to 0 when a same-cycle write to addr is being bypassed.
  - A same-cycle issue does not affect them (registered effect only).
- busy_count:
  - Registered count of set busy bits, updated on the same edge as the busy bits.
  - Range 0..2**ADDR_W-1 with ZERO_REG=1.
  - Maintained incrementally: +1 per newly set bit, -1 per newly cleared bit; never underflows.
- Writes to a non-busy register are legal and update data with no scoreboard change.
- Reset asserted mid-operation: state clears immediately; in-flight writes that cycle are lost.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults and the zero-register address constant.
- One natural sub-module: regfile_bypass_mux, the per-read-port bypass/zero/priority select, instantiated twice.
- Scoreboard and count stay in the top.

Test Plan:
1. Reset, then read addresses 0..31 -> all data 0, busy 0, busy_count 0, equal 1.
2. Both ports write address 7 in the same cycle: we0 with wd0=0x11, we1 with wd1=0x22 -> same-cycle read_data_1=0x22 via bypass; next cycle regs[7] reads 0x22.
3. Write wa0=0, wd0=0xFFFF_FFFF; issue address 0 -> reads 0, rs_busy 0, busy_count unchanged.
4. Issue address 5, next cycle write address 5 = 0xABCD:
   - After the issue: busy_count=1 and rs_busy=1 at rs_addr=5.
   - In the write cycle: rs_busy=0 and read_data_1=0xABCD.
   - After the write edge: busy_count=0.
5. Same cycle issue address 9 and write address 9 = 0x1 -> after the edge busy[9]=1, busy_count +1, data 0x1.
6. Set busy on addresses 3 and 4, write rs=rt=3 data 0x5, assert reset mid-sequence -> all outputs return to reset values within the reset cycle; equal 1.
